// File: rtl/aes_round_pipe.sv
// aes_round_pipe: one AES encryption round (SubBytes, ShiftRows, optional
// MixColumns, AddRoundKey) as a 1..3 stage valid/ready pipeline. Key, final
// flag and tag ride alongside the state in every stage register.

// One S-box lane: GF(2^8) inverse (x^254) followed by the FIPS-197 affine map.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] s
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p, t;
    p = '0;
    t = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rol(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  logic [7:0] x2, x3, x12, x15, x240, inv;

  // Addition chain to x^254; zero maps to zero, matching the S-box definition.
  always_comb begin
    x2   = gmul(a, a);
    x3   = gmul(x2, a);
    x12  = gmul(gmul(x3, x3), gmul(x3, x3));
    x15  = gmul(x12, x3);
    x240 = gmul(x15, x15);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    x240 = gmul(x240, x240);
    inv  = gmul(gmul(x240, x12), x2);
    s    = inv ^ rol(inv, 1) ^ rol(inv, 2) ^ rol(inv, 3) ^ rol(inv, 4) ^ 8'h63;
  end
endmodule

// One MixColumns lane: a single 4-byte column, byte 0 in [31:24].
module aes_mixcol (
  input  logic [31:0] col,
  output logic [31:0] mix
);
  function automatic logic [7:0] xt(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;
  assign mix = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
endmodule

module aes_round_pipe #(
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input  logic             round_clk,
  input  logic             round_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic             in_final,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int LAST      = PIPE_STAGES - 1;
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic [127:0]     data;
    logic [127:0]     key;
    logic             fin;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t [PIPE_STAGES-1:0] st_d, st_q;
  logic [PIPE_STAGES-1:0]   vld_pipe, adv, load;
  logic                     in_fire, tail_full, unused_bits;

  logic [127:0] sb_out, sr_out, mc_in, mc_out, mx_out, ark_in, ark_key, ark_out;
  logic         mc_fin;

  // SubBytes on the raw input bytes, then ShiftRows as pure wiring.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (.a(in_data[127-8*i -: 8]), .s(sb_out[127-8*i -: 8]));
  end

  for (genvar c = 0; c < NUM_LANES; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_out[127-8*(r+4*c) -: 8] = sb_out[127-8*(r+4*((c+r)%4)) -: 8];
    end
    aes_mixcol u_mix (.col(mc_in[127-32*c -: 32]), .mix(mc_out[127-32*c -: 32]));
  end

  assign mx_out  = mc_fin ? mc_in : mc_out;
  assign ark_out = ark_in ^ ark_key;

  // Where MixColumns and AddRoundKey draw their operands depends on depth.
  if (PIPE_STAGES == 1) begin : g_d1
    assign mc_in   = sr_out;
    assign mc_fin  = in_final;
    assign ark_in  = mx_out;
    assign ark_key = in_key;
  end else if (PIPE_STAGES == 2) begin : g_d2
    assign mc_in   = st_q[0].data;
    assign mc_fin  = st_q[0].fin;
    assign ark_in  = mx_out;
    assign ark_key = st_q[0].key;
  end else begin : g_d3
    assign mc_in   = st_q[0].data;
    assign mc_fin  = st_q[0].fin;
    assign ark_in  = st_q[1].data;
    assign ark_key = st_q[1].key;
  end

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    logic [127:0] nxt;
    if (k == LAST) begin : g_ark
      assign nxt = ark_out;
    end else if (k == 0) begin : g_sr
      assign nxt = sr_out;
    end else begin : g_mc
      assign nxt = mx_out;
    end
    if (k == 0) begin : g_head
      assign st_d[k] = '{data: nxt, key: in_key, fin: in_final, tag: in_tag};
    end else begin : g_body
      assign st_d[k] = '{data: nxt, key: st_q[k-1].key, fin: st_q[k-1].fin,
                         tag: st_q[k-1].tag};
    end
  end

  // Stage k advances unless it and every stage after it are full while the
  // consumer stalls; closed form of the backward advance chain.
  always_comb begin
    tail_full = 1'b1;
    adv       = '0;
    for (int k = LAST; k >= 0; k--) begin
      tail_full = tail_full & vld_pipe[k];
      adv[k]    = vld_pipe[k] & ~(tail_full & ~out_ready);
    end
  end

  assign in_ready = ~vld_pipe[0] | adv[0];
  assign in_fire  = in_valid & in_ready;

  // Stage 0 loads on input transfer, later stages when their predecessor advances.
  always_comb begin
    load    = '0;
    load[0] = in_fire;
    for (int k = 1; k < PIPE_STAGES; k++) load[k] = adv[k-1];
  end

  // Valid bits and payloads; payloads change only when their stage loads.
  always_ff @(posedge round_clk or negedge round_rst_n) begin
    if (!round_rst_n) begin
      vld_pipe <= '0;
      st_q     <= '0;
    end else begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        if (load[k]) begin
          vld_pipe[k] <= 1'b1;
          st_q[k]     <= st_d[k];
        end else if (adv[k]) begin
          vld_pipe[k] <= 1'b0;
        end
      end
    end
  end

  // Sideband bits past their last consumer are intentionally dropped.
  always_comb begin
    unused_bits = ^st_q[LAST].key;
    for (int k = 0; k < PIPE_STAGES; k++) unused_bits = unused_bits ^ st_q[k].fin;
  end

  assign out_valid = vld_pipe[LAST];
  assign out_data  = st_q[LAST].data;
  assign out_tag   = st_q[LAST].tag;
  assign busy      = |vld_pipe;
endmodule

// File: tb/tb_aes_round_pipe.sv
// Directed bench for aes_round_pipe: FIPS-197 round vectors at depths 1..3,
// streaming, stall/backpressure and reset behaviour on the 3-stage instance.
module tb_aes_round_pipe;
  localparam logic [127:0] R1_IN   = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R10_IN  = 128'heb40f21e592e38848ba113e71bc342d2;
  localparam logic [127:0] R10_KEY = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R10_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
  // Round output before AddRoundKey; any key then yields X ^ key.
  localparam logic [127:0] X1  = R1_OUT ^ R1_KEY;
  localparam logic [127:0] X10 = R10_OUT ^ R10_KEY;
  localparam logic [127:0] X0  = {16{8'h63}};   // all-zero input, non-final

  logic round_clk = 1'b0;
  always #5 round_clk = ~round_clk;

  logic         round_rst_n;
  logic [127:0] in_data, in_key;
  logic         in_final;
  logic [3:0]   in_tag;
  logic         iv1, iv2, iv3, or1, or2, or3;
  logic         ir1, ir2, ir3, ov1, ov2, ov3, bz1, bz2, bz3;
  logic [127:0] od1, od2, od3;
  logic [3:0]   ot1, ot2, ot3;

  aes_round_pipe #(.PIPE_STAGES(3), .TAG_W(4)) u_dut3 (
    .round_clk(round_clk), .round_rst_n(round_rst_n), .in_valid(iv3), .in_ready(ir3),
    .in_data(in_data), .in_key(in_key), .in_final(in_final), .in_tag(in_tag),
    .out_valid(ov3), .out_ready(or3), .out_data(od3), .out_tag(ot3), .busy(bz3));
  aes_round_pipe #(.PIPE_STAGES(2), .TAG_W(4)) u_dut2 (
    .round_clk(round_clk), .round_rst_n(round_rst_n), .in_valid(iv2), .in_ready(ir2),
    .in_data(in_data), .in_key(in_key), .in_final(in_final), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_tag(ot2), .busy(bz2));
  aes_round_pipe #(.PIPE_STAGES(1), .TAG_W(4)) u_dut1 (
    .round_clk(round_clk), .round_rst_n(round_rst_n), .in_valid(iv1), .in_ready(ir1),
    .in_data(in_data), .in_key(in_key), .in_final(in_final), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_tag(ot1), .busy(bz1));

  int vec_cnt = 0;
  int err_cnt = 0;
  logic [127:0] expq[$];
  logic [3:0]   tagq[$];

  function automatic logic sel_ov(input int ps);
    return (ps == 1) ? ov1 : (ps == 2) ? ov2 : ov3;
  endfunction
  function automatic logic sel_ir(input int ps);
    return (ps == 1) ? ir1 : (ps == 2) ? ir2 : ir3;
  endfunction
  function automatic logic [127:0] sel_od(input int ps);
    return (ps == 1) ? od1 : (ps == 2) ? od2 : od3;
  endfunction
  function automatic logic [3:0] sel_ot(input int ps);
    return (ps == 1) ? ot1 : (ps == 2) ? ot2 : ot3;
  endfunction

  task automatic set_iv(input int ps, input logic v);
    iv1 = (ps == 1) ? v : 1'b0;
    iv2 = (ps == 2) ? v : 1'b0;
    iv3 = (ps == 3) ? v : 1'b0;
  endtask

  // Drive transaction idx on the shared inputs and queue its expected result.
  task automatic apply_item(input int idx);
    logic [127:0] k;
    k = {$urandom, $urandom, $urandom, $urandom};
    case (idx % 3)
      0:       begin in_data = R1_IN;  in_final = 1'b0; expq.push_back(X1 ^ k);  end
      1:       begin in_data = R10_IN; in_final = 1'b1; expq.push_back(X10 ^ k); end
      default: begin in_data = '0;     in_final = 1'b0; expq.push_back(X0 ^ k);  end
    endcase
    in_key = k;
    in_tag = 4'(idx % 16);
    tagq.push_back(4'(idx % 16));
  endtask

  task automatic test_reset();
    round_rst_n = 1'b0;
    in_data = '0; in_key = '0; in_final = 1'b0; in_tag = '0;
    iv1 = 1'b0; iv2 = 1'b0; iv3 = 1'b0;
    or1 = 1'b1; or2 = 1'b1; or3 = 1'b1;
    #1;
    vec_cnt++; if (ov3 !== 1'b0) begin err_cnt++; $display("FAIL rst_out_valid: got %b want 0", ov3); end
    vec_cnt++; if (bz3 !== 1'b0) begin err_cnt++; $display("FAIL rst_busy: got %b want 0", bz3); end
    vec_cnt++; if (od3 !== '0) begin err_cnt++; $display("FAIL rst_out_data: got %h want 0", od3); end
    vec_cnt++; if (ot3 !== 4'h0) begin err_cnt++; $display("FAIL rst_out_tag: got %h want 0", ot3); end
    repeat (2) @(posedge round_clk);
    @(negedge round_clk);
    round_rst_n = 1'b1;
    #1;
    vec_cnt++; if ({ir1, ir2, ir3} !== 3'b111) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 111", {ir1, ir2, ir3}); end
    @(posedge round_clk); #1;
  endtask

  // Round 1, round 10 and the all-zero result through one depth, checking latency.
  task automatic test_round(input int ps);
    logic [127:0] d[3], k[3], e[3];
    logic         f[3];
    d = '{R1_IN, R10_IN, 128'h0};
    k = '{R1_KEY, R10_KEY, X0};
    e = '{R1_OUT, R10_OUT, 128'h0};
    f = '{1'b0, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      int lat;
      in_data = d[v]; in_key = k[v]; in_final = f[v]; in_tag = 4'(5 + v);
      set_iv(ps, 1'b1);
      @(negedge round_clk);
      vec_cnt++; if (sel_ir(ps) !== 1'b1) begin err_cnt++; $display("FAIL ready ps=%0d v=%0d: got %b want 1", ps, v, sel_ir(ps)); end
      @(posedge round_clk); #1;
      set_iv(ps, 1'b0);
      lat = 1;
      @(negedge round_clk);
      while (sel_ov(ps) !== 1'b1 && lat < 8) begin
        @(negedge round_clk);
        lat++;
      end
      vec_cnt++; if (lat != ps) begin err_cnt++; $display("FAIL latency ps=%0d v=%0d: got %0d want %0d", ps, v, lat, ps); end
      vec_cnt++; if (sel_od(ps) !== e[v]) begin err_cnt++; $display("FAIL data ps=%0d v=%0d: got %h want %h", ps, v, sel_od(ps), e[v]); end
      vec_cnt++; if (sel_ot(ps) !== 4'(5 + v)) begin err_cnt++; $display("FAIL tag ps=%0d v=%0d: got %h want %h", ps, v, sel_ot(ps), 4'(5 + v)); end
      @(posedge round_clk); #1;
      @(negedge round_clk);
      vec_cnt++; if (sel_ov(ps) !== 1'b0) begin err_cnt++; $display("FAIL drain ps=%0d v=%0d: got %b want 0", ps, v, sel_ov(ps)); end
      @(posedge round_clk); #1;
    end
  endtask

  // n transactions into the 3-stage pipe; rnd=0 holds out_ready high and
  // demands full throughput, rnd=1 toggles out_ready pseudo-randomly.
  task automatic test_stream(input int n, input bit rnd);
    int nin, nout, cyc, last_out;
    bit fi, fo;
    expq.delete(); tagq.delete();
    nin = 0; nout = 0; cyc = 0; last_out = -1;
    or3 = 1'b1;
    apply_item(0);
    iv3 = 1'b1;
    while (nout < n && cyc < 400) begin
      @(negedge round_clk);
      fi = iv3 & ir3;
      fo = ov3 & or3;
      if (!rnd && iv3) begin
        vec_cnt++; if (ir3 !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready cyc=%0d: got %b want 1", cyc, ir3); end
      end
      if (fo) begin
        vec_cnt++; if (od3 !== expq[nout]) begin err_cnt++; $display("FAIL stream_data #%0d: got %h want %h", nout, od3, expq[nout]); end
        vec_cnt++; if (ot3 !== tagq[nout]) begin err_cnt++; $display("FAIL stream_tag #%0d: got %h want %h", nout, ot3, tagq[nout]); end
        if (!rnd && last_out >= 0) begin
          vec_cnt++; if (cyc != last_out + 1) begin err_cnt++; $display("FAIL b2b_gap #%0d: got cycle %0d want %0d", nout, cyc, last_out + 1); end
        end
        last_out = cyc;
        nout++;
      end
      @(posedge round_clk); #1;
      if (fi) begin
        nin++;
        if (nin < n) apply_item(nin); else iv3 = 1'b0;
      end
      if (rnd) or3 = 1'($urandom_range(0, 1));
      cyc++;
    end
    vec_cnt++; if (nout != n) begin err_cnt++; $display("FAIL stream_count: got %0d want %0d", nout, n); end
    iv3 = 1'b0; or3 = 1'b1;
    @(posedge round_clk); #1;
  endtask

  // Five offered with the consumer stalled: three accepted, output held, all delivered on release.
  task automatic test_stall();
    int nin, nout, cyc;
    bit fi, fo;
    expq.delete(); tagq.delete();
    nin = 0; nout = 0; cyc = 0;
    or3 = 1'b0;
    apply_item(0);
    iv3 = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge round_clk);
      fi = iv3 & ir3;
      @(posedge round_clk); #1;
      if (fi) begin
        nin++;
        if (nin < 5) apply_item(nin); else iv3 = 1'b0;
      end
    end
    @(negedge round_clk);
    vec_cnt++; if (nin != 3) begin err_cnt++; $display("FAIL stall_accepts: got %0d want 3", nin); end
    vec_cnt++; if (ir3 !== 1'b0) begin err_cnt++; $display("FAIL stall_in_ready: got %b want 0", ir3); end
    vec_cnt++; if (ov3 !== 1'b1) begin err_cnt++; $display("FAIL stall_out_valid: got %b want 1", ov3); end
    vec_cnt++; if (od3 !== expq[0]) begin err_cnt++; $display("FAIL stall_hold_data: got %h want %h", od3, expq[0]); end
    vec_cnt++; if (ot3 !== tagq[0]) begin err_cnt++; $display("FAIL stall_hold_tag: got %h want %h", ot3, tagq[0]); end
    @(posedge round_clk); #1;
    or3 = 1'b1;
    while (nout < 5 && cyc < 40) begin
      @(negedge round_clk);
      fi = iv3 & ir3;
      fo = ov3 & or3;
      if (fo) begin
        vec_cnt++; if (od3 !== expq[nout]) begin err_cnt++; $display("FAIL release_data #%0d: got %h want %h", nout, od3, expq[nout]); end
        vec_cnt++; if (ot3 !== tagq[nout]) begin err_cnt++; $display("FAIL release_tag #%0d: got %h want %h", nout, ot3, tagq[nout]); end
        nout++;
      end
      @(posedge round_clk); #1;
      if (fi) begin
        nin++;
        if (nin < 5) apply_item(nin); else iv3 = 1'b0;
      end
      cyc++;
    end
    vec_cnt++; if (nout != 5) begin err_cnt++; $display("FAIL release_count: got %0d want 5", nout); end
    iv3 = 1'b0;
  endtask

  // Three in flight, reset asserted between edges: outputs clear at once, nothing stale later.
  task automatic test_reset_midflight();
    bit stale;
    expq.delete(); tagq.delete();
    or3 = 1'b0;
    apply_item(0);
    iv3 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge round_clk); #1;
      if (c < 3) apply_item(c); else iv3 = 1'b0;
    end
    @(negedge round_clk);
    vec_cnt++; if ({bz3, ov3} !== 2'b11) begin err_cnt++; $display("FAIL pre_reset_busy_valid: got %b want 11", {bz3, ov3}); end
    #2;
    round_rst_n = 1'b0;
    #1;
    vec_cnt++; if (ov3 !== 1'b0) begin err_cnt++; $display("FAIL midrst_out_valid: got %b want 0", ov3); end
    vec_cnt++; if (bz3 !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b want 0", bz3); end
    vec_cnt++; if (od3 !== '0) begin err_cnt++; $display("FAIL midrst_out_data: got %h want 0", od3); end
    @(negedge round_clk);
    round_rst_n = 1'b1;
    or3 = 1'b1;
    stale = 1'b0;
    repeat (8) begin
      @(negedge round_clk);
      if (ov3 !== 1'b0 || bz3 !== 1'b0) stale = 1'b1;
    end
    vec_cnt++; if (stale !== 1'b0) begin err_cnt++; $display("FAIL post_reset_stale: got %b want 0", stale); end
    @(posedge round_clk); #1;
  endtask

  initial begin
    test_reset();
    test_round(3);
    test_round(2);
    test_round(1);
    test_stream(8, 1'b0);
    test_stream(20, 1'b1);
    test_stall();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
